// File: rtl/cla_pkg.sv
// Shared helpers for the pipelined CLA adder: stage-count derivation and
// configuration legality.
package cla_pkg;

  // An illegal WIDTH/BLOCK/GROUP mix yields zero stages, so the stage arrays
  // sized by this value fail to elaborate instead of silently misbehaving.
  function automatic int unsigned stages(input int unsigned w, input int unsigned b,
                                         input int unsigned g);
    if (b == 0 || g == 0 || (w % b) != 0 || (b % g) != 0) return 0;
    return w / b;
  endfunction

  function automatic bit cfg_ok(input int unsigned w, input int unsigned b,
                                input int unsigned g);
    return stages(w, b, g) != 0;
  endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational BLOCK-bit carry look-ahead slice built from GROUP-bit P/G groups;
// also exposes the carry into the MSB for signed-overflow detection.
module cla_slice
  import cla_pkg::*;
#(
  parameter int unsigned BLOCK = 8,
  parameter int unsigned GROUP = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout,
  output logic             cmsb
);
  localparam int unsigned NG = BLOCK / GROUP;

  logic [BLOCK-1:0] p, g;
  logic [NG-1:0]    gp, gg;
  logic [NG:0]      gc;
  logic [BLOCK:0]   c;

  assign p = a ^ b;
  assign g = a & b;

  always_comb begin
    gp = '0;
    gg = '0;
    gc = '0;
    c  = '0;
    // Level 1: group propagate/generate.
    for (int j = 0; j < NG; j++) begin
      gp[j] = 1'b1;
      for (int i = 0; i < GROUP; i++) begin
        gg[j] = g[j*GROUP+i] | (p[j*GROUP+i] & gg[j]);
        gp[j] = gp[j] & p[j*GROUP+i];
      end
    end
    // Level 2: group carries, then bit carries inside each group.
    gc[0] = cin;
    for (int j = 0; j < NG; j++) gc[j+1] = gg[j] | (gp[j] & gc[j]);
    for (int j = 0; j < NG; j++) begin
      c[j*GROUP] = gc[j];
      for (int i = 0; i < GROUP - 1; i++)
        c[j*GROUP+i+1] = g[j*GROUP+i] | (p[j*GROUP+i] & c[j*GROUP+i]);
    end
    c[BLOCK] = gc[NG];
  end

  assign sum  = p ^ c[BLOCK-1:0];
  assign cout = c[BLOCK];
  assign cmsb = c[BLOCK-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined CLA adder/subtractor, one BLOCK-bit slice per stage, valid/ready wrapped.
// Define CLA_SAT_EN for signed saturation of the result on overflow.
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BLOCK = 8,
  parameter int unsigned GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inp_valid,
  output logic             inp_ready,
  input  logic [WIDTH-1:0] inp_a,
  input  logic [WIDTH-1:0] inp_b,
  input  logic             inp_cin,
  input  logic             inp_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_cout,
  output logic             out_ovf
);
  localparam int unsigned L = stages(WIDTH, BLOCK, GROUP);

  // a_hi/b_hi skew the unconsumed operand slices; s_lo deskews finished ones.
  typedef struct packed {
    logic             valid;
    logic             carry;
    logic [WIDTH-1:0] a_hi;
    logic [WIDTH-1:0] b_hi;
    logic [WIDTH-1:0] s_lo;
  } stage_t;

  stage_t           stg_q [L];
  logic             ovf_q;
  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic [BLOCK-1:0] sl_a [L];
  logic [BLOCK-1:0] sl_b [L];
  logic [BLOCK-1:0] sl_sum [L];
  logic             sl_cin [L];
  logic             sl_cout [L];
  logic             sl_cmsb [L];
  logic [WIDTH-1:0] s_nx [L];
  logic [WIDTH-1:0] s_fin;
  logic             ovf_nx;

  assign advance   = !stg_q[L-1].valid || out_ready;
  assign inp_ready = advance;
  assign b_eff     = inp_sub ? ~inp_b : inp_b;
  assign cin_eff   = inp_sub | inp_cin;

  for (genvar k = 0; k < L; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign sl_a[k]   = inp_a[BLOCK-1:0];
      assign sl_b[k]   = b_eff[BLOCK-1:0];
      assign sl_cin[k] = cin_eff;
      assign s_nx[k]   = WIDTH'(sl_sum[k]);
    end else begin : g_next
      assign sl_a[k]   = stg_q[k-1].a_hi[k*BLOCK +: BLOCK];
      assign sl_b[k]   = stg_q[k-1].b_hi[k*BLOCK +: BLOCK];
      assign sl_cin[k] = stg_q[k-1].carry;
      // Bits at and above this slice are still zero in s_lo, so OR inserts it.
      assign s_nx[k]   = stg_q[k-1].s_lo | (WIDTH'(sl_sum[k]) << (k*BLOCK));
    end
    cla_slice #(.BLOCK(BLOCK), .GROUP(GROUP)) u_slice (
      .a   (sl_a[k]),
      .b   (sl_b[k]),
      .cin (sl_cin[k]),
      .sum (sl_sum[k]),
      .cout(sl_cout[k]),
      .cmsb(sl_cmsb[k])
    );
  end

  assign ovf_nx = sl_cmsb[L-1] ^ sl_cout[L-1];

  always_comb begin
    s_fin = s_nx[L-1];
`ifdef CLA_SAT_EN
    // Both effective operands share A's sign when overflow occurs.
    if (ovf_nx)
      s_fin = sl_a[L-1][BLOCK-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < L; k++) stg_q[k] <= '0;
      ovf_q <= 1'b0;
    end else if (advance) begin
      stg_q[0] <= '{valid: inp_valid, carry: sl_cout[0], a_hi: inp_a, b_hi: b_eff,
                    s_lo: s_nx[0]};
      for (int k = 1; k < L; k++)
        stg_q[k] <= '{valid: stg_q[k-1].valid, carry: sl_cout[k], a_hi: stg_q[k-1].a_hi,
                      b_hi: stg_q[k-1].b_hi, s_lo: s_nx[k]};
      stg_q[L-1].s_lo <= s_fin;
      ovf_q           <= ovf_nx;
    end
  end

  assign out_valid = stg_q[L-1].valid;
  assign out_s     = stg_q[L-1].s_lo;
  assign out_cout  = stg_q[L-1].carry;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder (default 32/8/4): directed table,
// latency, backpressure, random stream against an arithmetic model, mid-stream reset.
module tb_pipelined_cla_adder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        inp_valid = 1'b0, inp_ready;
  logic [31:0] inp_a = '0, inp_b = '0;
  logic        inp_cin = 1'b0, inp_sub = 1'b0;
  logic        out_valid, out_ready = 1'b1;
  logic [31:0] out_s;
  logic        out_cout, out_ovf;

  always #5 clk = ~clk;

  pipelined_cla_adder dut (
    .clk(clk), .rst_n(rst_n), .inp_valid(inp_valid), .inp_ready(inp_ready),
    .inp_a(inp_a), .inp_b(inp_b), .inp_cin(inp_cin), .inp_sub(inp_sub),
    .out_valid(out_valid), .out_ready(out_ready), .out_s(out_s),
    .out_cout(out_cout), .out_ovf(out_ovf)
  );

  typedef struct {logic [31:0] s; logic cout; logic ovf;} res_t;
  typedef struct {
    logic [31:0] a, b; logic cin, sub;
    logic [31:0] s; logic cout, ovf;
  } vec_t;

  res_t exp_q[$];
  int   ncmp = 0, nerr = 0, npop = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic res_t model(input logic [31:0] a, b, input logic cin, sub);
    res_t r;
    logic [31:0] bb;
    logic [32:0] full;
    bb    = sub ? ~b : b;
    full  = {1'b0, a} + {1'b0, bb} + {32'd0, (sub | cin)};
    r.s    = full[31:0];
    r.cout = full[32];
    r.ovf  = (a[31] == bb[31]) && (full[31] != a[31]);
`ifdef CLA_SAT_EN
    if (r.ovf) r.s = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    return r;
  endfunction

  // One cycle: drive at negedge, sample 1ns later, scoreboard both transfers.
  task automatic step(input logic v, input logic [31:0] a, b, input logic cin, sub, ordy,
                      output logic acc, output logic seen, output logic rdy);
    res_t e;
    @(negedge clk);
    inp_valid = v; inp_a = a; inp_b = b; inp_cin = cin; inp_sub = sub; out_ready = ordy;
    #1;
    rdy  = inp_ready;
    acc  = v && inp_ready;
    seen = out_valid && ordy;
    if (seen) begin
      npop++;
      if (exp_q.size() == 0) begin
        ncmp++; nerr++;
        $display("FAIL unexpected_beat: got s=%0h with no beat outstanding", out_s);
      end else begin
        e = exp_q.pop_front();
        chk("sb_s", out_s, e.s);
        chk("sb_cout", out_cout, e.cout);
        chk("sb_ovf", out_ovf, e.ovf);
      end
    end
    if (acc) exp_q.push_back(model(a, b, cin, sub));
  endtask

  task automatic idle(input logic ordy, output logic seen);
    logic acc, rdy;
    step(1'b0, '0, '0, 1'b0, 1'b0, ordy, acc, seen, rdy);
  endtask

  initial begin
    vec_t        tbl[8];
    logic        acc, seen, rdy, ordy, v;
    logic [31:0] hold_s, ra, rb, ov_p, ov_n, ov_nn;
    int          first, sent, c, base, w;

`ifdef CLA_SAT_EN
    ov_p = 32'h7FFF_FFFF; ov_n = 32'h8000_0000; ov_nn = 32'h8000_0000;
`else
    ov_p = 32'h8000_0000; ov_n = 32'h7FFF_FFFF; ov_nn = 32'h0000_0000;
`endif
    tbl[0] = '{32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0};
    tbl[1] = '{32'h5, 32'h7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    tbl[2] = '{32'h7, 32'h5, 1'b0, 1'b1, 32'h2, 1'b1, 1'b0};
    tbl[3] = '{32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, ov_p, 1'b0, 1'b1};
    tbl[4] = '{32'h8000_0000, 32'h1, 1'b0, 1'b1, ov_n, 1'b1, 1'b1};
    tbl[5] = '{32'h0000_FFFF, 32'h0000_FF01, 1'b1, 1'b0, 32'h0001_FF01, 1'b0, 1'b0};
    tbl[6] = '{32'd10, 32'd3, 1'b1, 1'b1, 32'd7, 1'b1, 1'b0};
    tbl[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, ov_nn, 1'b1, 1'b1};

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_s", out_s, 0);
    chk("rst_out_cout", out_cout, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_inp_ready", inp_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Latency: 3+4 accepted on the first edge after reset release
    step(1'b1, 32'd3, 32'd4, 1'b0, 1'b0, 1'b1, acc, seen, rdy);
    chk("lat_accept", acc, 1);
    first = 0;
    for (int i = 1; i <= 8; i++) begin
      idle(1'b1, seen);
      if (seen && first == 0) begin
        first = i;
        chk("lat_sum", out_s, 32'd7);
      end
    end
    chk("lat_cycles", first, 4);

    // Directed table
    foreach (tbl[n]) begin
      step(1'b1, tbl[n].a, tbl[n].b, tbl[n].cin, tbl[n].sub, 1'b1, acc, seen, rdy);
      seen = 1'b0;
      for (int t = 0; t < 10 && !seen; t++) idle(1'b1, seen);
      if (!seen) begin
        ncmp++; nerr++;
        $display("FAIL tbl_timeout: vector %0d produced no output", n);
      end else begin
        chk($sformatf("tbl%0d_s", n), out_s, tbl[n].s);
        chk($sformatf("tbl%0d_cout", n), out_cout, tbl[n].cout);
        chk($sformatf("tbl%0d_ovf", n), out_ovf, tbl[n].ovf);
      end
    end

    // Backpressure: 64 beats i+j back-to-back, out_ready low for cycles 20..22
    sent = 0; c = 0; base = npop; hold_s = '0;
    while ((npop - base) < 64 && c < 300) begin
      ordy = !(c >= 20 && c < 23);
      step(sent < 64, 32'(sent / 8), 32'(sent % 8), 1'b0, 1'b0, ordy, acc, seen, rdy);
      chk("bp_inp_ready", rdy, ordy);
      if (c == 20) hold_s = out_s;
      if (c == 21 || c == 22) chk("bp_stall_stable", out_s, hold_s);
      if (acc) sent++;
      c++;
    end
    chk("bp_count", npop - base, 64);

    // Random stream with random backpressure and corner-biased operands
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      w = $urandom_range(0, 5);
      ra = (w == 0) ? 32'h7FFF_FFFF : (w == 1) ? 32'h8000_0000 : (w == 2) ? 32'hFFFF_FFFF : $urandom;
      w = $urandom_range(0, 5);
      rb = (w == 0) ? 32'h1 : (w == 1) ? 32'h8000_0000 : (w == 2) ? 32'hFFFF_FFFF : $urandom;
      step(v, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ordy, acc, seen, rdy);
    end
    for (int t = 0; t < 20 && exp_q.size() != 0; t++) idle(1'b1, seen);
    chk("rand_drain_empty", exp_q.size(), 0);

    // Reset while 4 beats are in flight
    for (int i = 0; i < 4; i++)
      step(1'b1, 32'(100 + i), 32'd1, 1'b0, 1'b0, 1'b1, acc, seen, rdy);
    @(posedge clk); #1;
    chk("mid_pre_valid", out_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_s", out_s, 0);
    chk("mid_rst_cout", out_cout, 0);
    chk("mid_rst_ovf", out_ovf, 0);
    chk("mid_rst_ready", inp_ready, 1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    inp_valid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      idle(1'b1, seen);
      chk("post_rst_no_beat", out_valid, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
